uart_tx_datapath: RTL and testbench
===================================

// Module: uart_tx_datapath
// PURPOSE
//  UART transmit datapath, downstream of the UART_TX control FSM.
//  - Captures a parallel word and computes its parity.
//  - Serializes the word LSB-first and reports ser_done to the FSM.
//  - Drives the TX line from the FSM's mux_sel: start / data / parity / stop.
//  - Single clock domain; TX_OUT is registered (glitch-free line).
// PARAMETERS
//  DATA_WIDTH  8  bits per frame payload; counter width = $clog2(DATA_WIDTH+1)
// PORTS
//  CLK         in   1           system clock, all logic on rising edge
//  RST         in   1           reset: synchronous, active-high
//  P_DATA      in   DATA_WIDTH  parallel payload
//  DATA_VALID  in   1           P_DATA valid this cycle
//  PAR_TYP     in   1           0 = even parity, 1 = odd parity
//  BUSY        in   1           FSM busy; blocks capture
//  ser_en      in   1           FSM serializer enable
//  mux_sel     in   2           FSM output select
//  ser_done    out  1           all DATA_WIDTH bits shifted out
//  TX_OUT      out  1           serial line (idle high)
// BEHAVIOUR
//  Reset: RST=1 at a rising edge clears all state in that cycle, including mid-frame:
//   shift_reg=0, bit_cnt=0, par_bit=0, ser_done=0, TX_OUT=1.
//  Capture: DATA_VALID=1 && BUSY=0 at an edge:
//   - shift_reg <= P_DATA
//   - par_bit <= PAR_TYP ? ~^P_DATA : ^P_DATA
//   - bit_cnt <= 0
//   DATA_VALID while BUSY=1 is ignored; the frame in flight is never corrupted.
//  Shift: ser_en=1 && mux_sel=2'b10 && bit_cnt<DATA_WIDTH at an edge:
//   - shift_reg <= shift_reg >> 1 (zero fill)
//   - bit_cnt <= bit_cnt + 1
//   ser_data = shift_reg[0] (combinational).
//  Saturate: bit_cnt never exceeds DATA_WIDTH; further shift requests are held.
//  Clear: ser_en=0 at an edge -> bit_cnt <= 0.
//   Releases ser_done during the stop/parity/idle cycles so the FSM can start the next frame.
//  ser_done = (bit_cnt == DATA_WIDTH). Combinational decode of a register, no input-to-output path.
//  TX_OUT mux, registered, 1-cycle latency from mux_sel:
//   00 -> 0 (start)   01 -> 1 (stop/idle)   10 -> ser_data   11 -> par_bit
//  Frame timing, FSM in lockstep, cycle 0 = capture edge:
//   - cycle 1: START, mux 00
//   - cycles 2..DATA_WIDTH+1: DATA, mux 10, bits LSB-first
//   - cycle DATA_WIDTH+2: ser_done=1; mux 11 if PAR_EN, else 01
//   - next: stop (01)
//   TX_OUT shows each symbol one cycle later.
//  Simultaneous capture and ser_en=0: capture wins for data; bit_cnt=0 either way.
//  Simultaneous capture and shift: capture wins.
//   Cannot occur with the FSM, since BUSY=1 in DATA.
//  Back-to-back frames: DATA_VALID held through the stop cycle.
//   Next capture occurs in IDLE with ser_done=0; no extra idle bit is required.
// TESTING
//  1. RST=1 mid-frame (cycle 5) -> next cycle TX_OUT=1, ser_done=0; bit_cnt=0 after release.
//  2. P_DATA=8'hA5, PAR_TYP=0, PAR_EN=1 -> TX_OUT=0,1,0,1,0,0,1,0,1,0(par),1.
//     ser_done high only on cycle 10.
//  3. P_DATA=8'h01, PAR_TYP=1, PAR_EN=1 -> data 1,0,0,0,0,0,0,0 then parity 0.
//     Repeat with PAR_TYP=0 -> parity 1.
//  4. P_DATA=8'hFF, PAR_EN=0 -> start 0, eight 1s, stop 1.
//     ser_done deasserts the cycle after stop.
//  5. DATA_VALID=1 with P_DATA=8'h3C pulsed during DATA of frame 8'hA5 -> A5 transmitted intact.
//  6. Back-to-back 8'h55 then 8'hAA, DATA_VALID held -> two frames.
//     Each frame: 1 start + 8 data + stop; second start immediately after IDLE.

Source files
------------

// File: rtl/uart_tx_if.sv
// Handshake bundle between the UART_TX control FSM (master) and the transmit datapath (slave).
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_TYP;
  logic                  BUSY;
  logic                  ser_en;
  logic [1:0]            mux_sel;
  logic                  ser_done;
  logic                  TX_OUT;

  modport master (
    output P_DATA, DATA_VALID, PAR_TYP, BUSY, ser_en, mux_sel,
    input  ser_done, TX_OUT
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_TYP, BUSY, ser_en, mux_sel,
    output ser_done, TX_OUT
  );
endinterface

// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: word capture with parity, LSB-first serializer and a registered
// TX line mux driven by the control FSM's select.
module uart_tx_datapath #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_if.slave       bus
);
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH);

  localparam logic [1:0] MuxStart  = 2'b00;
  localparam logic [1:0] MuxStop   = 2'b01;
  localparam logic [1:0] MuxData   = 2'b10;
  localparam logic [1:0] MuxParity = 2'b11;

  logic [DATA_WIDTH-1:0] shift_d, shift_q;
  logic [CntW-1:0]       bit_cnt_d, bit_cnt_q;
  logic                  par_bit_d, par_bit_q;
  logic                  tx_out_d, tx_out_q;
  logic                  capture;
  logic                  shift_req;
  logic                  ser_data;

  assign capture   = bus.DATA_VALID && !bus.BUSY;
  assign shift_req = bus.ser_en && (bus.mux_sel == MuxData) && (bit_cnt_q < CntMax);
  assign ser_data  = shift_q[0];

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_bit_d = par_bit_q;
    // Capture has priority so a new word always starts from a clean count.
    if (capture) begin
      shift_d   = bus.P_DATA;
      par_bit_d = bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
      bit_cnt_d = '0;
    end else if (!bus.ser_en) begin
      bit_cnt_d = '0;
    end else if (shift_req) begin
      shift_d   = shift_q >> 1;
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_comb begin
    tx_out_d = 1'b1;
    unique case (bus.mux_sel)
      MuxStart:  tx_out_d = 1'b0;
      MuxStop:   tx_out_d = 1'b1;
      MuxData:   tx_out_d = ser_data;
      MuxParity: tx_out_d = par_bit_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_bit_q <= 1'b0;
      tx_out_q  <= 1'b1;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_bit_q <= par_bit_d;
      tx_out_q  <= tx_out_d;
    end
  end

  assign bus.ser_done = (bit_cnt_q == CntMax);
  assign bus.TX_OUT   = tx_out_q;
endmodule

// File: tb/tb_uart_tx_datapath.sv
// Directed bench for uart_tx_datapath: drives FSM-lockstep frames and scoreboards TX_OUT.
module tb_uart_tx_datapath;
  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_datapath #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic par_of(input logic [7:0] d, input logic pt);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // One FSM cycle: inputs applied just after an edge, ser_done checked in-cycle,
  // expected TX symbol pushed and compared just after the following edge.
  task automatic step(input logic [1:0] ms, input logic se, input logic busy, input logic dv,
                      input logic [7:0] pd, input logic pt, input logic exp_tx,
                      input logic exp_done, input string tag);
    logic exp;
    bus.mux_sel    = ms;
    bus.ser_en     = se;
    bus.BUSY       = busy;
    bus.DATA_VALID = dv;
    bus.P_DATA     = pd;
    bus.PAR_TYP    = pt;
    exp_q.push_back(exp_tx);
    #1;
    checks++;
    assert (bus.ser_done === exp_done) else begin
      errors++;
      $error("FAIL %s ser_done: got %b expected %b", tag, bus.ser_done, exp_done);
    end
    @(posedge CLK);
    #1;
    exp = exp_q.pop_front();
    checks++;
    assert (bus.TX_OUT === exp) else begin
      errors++;
      $error("FAIL %s tx_out: got %b expected %b", tag, bus.TX_OUT, exp);
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic pt, input logic pen,
                       input logic glitch, input logic hold_dv, input string tag);
    step(2'b01, 1'b0, 1'b0, 1'b1, d, pt, 1'b1, 1'b0, {tag, " cap"});
    step(2'b00, 1'b1, 1'b1, 1'b0, d, pt, 1'b0, 1'b0, {tag, " start"});
    for (int i = 0; i < 8; i++) begin
      if (glitch && (i == 3 || i == 4))
        step(2'b10, 1'b1, 1'b1, 1'b1, 8'h3C, ~pt, d[i], 1'b0, {tag, " data"});
      else
        step(2'b10, 1'b1, 1'b1, 1'b0, d, pt, d[i], 1'b0, {tag, " data"});
    end
    if (pen) begin
      step(2'b11, 1'b0, 1'b1, 1'b0, d, pt, par_of(d, pt), 1'b1, {tag, " parity"});
      step(2'b01, 1'b0, 1'b1, hold_dv, d, pt, 1'b1, 1'b0, {tag, " stop"});
    end else begin
      step(2'b01, 1'b0, 1'b1, hold_dv, d, pt, 1'b1, 1'b1, {tag, " stop"});
    end
  endtask

  initial begin
    RST            = 1'b1;
    bus.P_DATA     = '0;
    bus.DATA_VALID = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.BUSY       = 1'b0;
    bus.ser_en     = 1'b0;
    bus.mux_sel    = 2'b00;
    @(posedge CLK);
    #1;
    // Start symbol selected during reset must still leave the line idle high.
    step(2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "reset");
    RST = 1'b0;
    step(2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "idle");

    // Reset mid-frame at cycle 5
    step(2'b01, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, "midrst cap");
    step(2'b00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, "midrst start");
    step(2'b10, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, "midrst d0");
    step(2'b10, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, "midrst d1");
    step(2'b10, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, "midrst d2");
    RST = 1'b1;
    step(2'b10, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, "midrst rst");
    RST = 1'b0;
    step(2'b01, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, "midrst release");

    frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, "a5_even");
    frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, "01_odd");
    frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, "01_even");
    frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "ff_nopar");
    step(2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "ff_after_stop");
    frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, "a5_glitch");
    frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_55");
    frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_aa");
    step(2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "final idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
